operand_slice_mux: RTL
======================

// Module: operand_slice_mux
// PURPOSE
//  Parametrised, registered operand slice selector for the sequential multiplier datapath.
//  Captures operands A and B on start_i and emits every (A-slice, B-slice) pair, one pair per beat.
//  Each beat carries the shift amount used to align the partial product.
//  Sits between the operand registers and the SLICE x SLICE multiplier/accumulator.
//  Replaces the fixed 2-input 4-bit selector with a counter-driven N-way selector under valid/ready.
// PARAMETERS
//  A_WIDTH  8  operand A width; must be a multiple of SLICE
//  B_WIDTH  8  operand B width; must be a multiple of SLICE
//  SLICE    4  slice width in bits; NA=A_WIDTH/SLICE, NB=B_WIDTH/SLICE
// PORTS
//  clk          in   1                             rising-edge clock
//  reset_n      in   1                             asynchronous active-low reset
//  start_i      in   1                             capture a_i/b_i and begin; honoured only in IDLE
//  a_i          in   A_WIDTH                       operand A
//  b_i          in   B_WIDTH                       operand B
//  busy_o       out  1                             high in RUN and DONE
//  out_valid_o  out  1                             slice pair valid
//  out_ready_i  in   1                             consumer accepts the pair
//  a_slice_o    out  SLICE                         A[i*SLICE +: SLICE]
//  b_slice_o    out  SLICE                         B[j*SLICE +: SLICE]
//  shift_o      out  $clog2(A_WIDTH+B_WIDTH)       (i+j)*SLICE
//  last_o       out  1                             current pair is i=NA-1, j=NB-1
//  done_o       out  1                             one-cycle pulse after the final pair completes
// BEHAVIOUR
//  - Reset (async, reset_n low):
//    - state=IDLE, i=j=0, operand registers=0.
//    - All outputs 0.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE:
//    - start_i=1 registers a_i/b_i and sets i=j=0; next cycle is RUN.
//  - RUN:
//    - out_valid_o=1 from the first RUN cycle (1-cycle latency from start_i).
//    - Pair order: i (A index) inner, j (B index) outer: (0,0),(1,0)...(NA-1,0),(0,1)...
//    - Indices advance only on out_valid_o && out_ready_i.
//    - All outputs are registered and stable while out_valid_o && !out_ready_i.
//    - last_o=1 only while presenting (NA-1,NB-1).
//    - Acceptance of that pair moves to DONE; out_valid_o drops in the same edge.
//  - DONE:
//    - done_o=1 for exactly one cycle, busy_o=1; then IDLE.
//  - start_i in RUN or DONE is ignored; captured operands are never disturbed mid-operation.
//  - shift_o max is (NA+NB-2)*SLICE and always fits its width; there is no overflow.
//  - Reset mid-operation aborts immediately to IDLE with outputs 0 and no done_o.
//  - start_i in the same cycle as the DONE->IDLE transition is ignored; start is accepted from IDLE only.
// CONFIGURATION
//  - SLICE_MUX_SKIP_ZERO_EN defined:
//    - In RUN, a pair where a_slice==0 or b_slice==0 is not presented (out_valid_o=0).
//    - The indices advance by one per cycle over such pairs.
//    - If (NA-1,NB-1) is skipped, no beat carries last_o=1; done_o still pulses.
//    - All-zero operand: NA*NB cycles of RUN with no beats, then done_o.
//  - SLICE_MUX_SKIP_ZERO_EN undefined:
//    - Every pair is presented, exactly NA*NB beats.
// STRUCTURE
//  - Package seq_mult_pkg:
//    - slice_mux_state_t enum {IDLE, RUN, DONE}
//    - function for shift width
//    - localparams NA and NB
//  - Sub-module slice_select: combinational N-to-1 selector, parameters WIDTH and SLICE, index input.
//    - Two instances: one for A, one for B.
//  - Top level: FSM, i/j counters, operand registers, output registers.
// TESTING
//  - 8x8/4, A=0xF0, B=0xC3, ready=1 -> beats (0,3,sh0), (F,3,sh4), (0,C,sh4), (F,C,sh8,last); done_o 1 cycle later.
//  - Same operands, ready low 3 cycles on beat 2 -> (F,3,sh4) held stable for 3 cycles; order unchanged.
//  - start_i pulsed during RUN with A=0xFF -> beats still use 0xF0; no restart.
//  - reset_n low after beat 1 -> outputs 0 immediately, no done_o; new start runs full sequence.
//  - SLICE_MUX_SKIP_ZERO_EN, A=0xF0, B=0xC3 -> only (F,3,sh4), (F,C,sh8,last); A=0 -> no beats, done_o after 4 RUN cycles.
//  - A_WIDTH=16, B_WIDTH=8, A=0x1234, B=0x56 -> 8 beats, last is (1,5,sh16).

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier datapath.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } slice_mux_state_t;

    localparam int unsigned DEF_A_WIDTH = 8;
    localparam int unsigned DEF_B_WIDTH = 8;
    localparam int unsigned DEF_SLICE   = 4;
    localparam int unsigned NA          = DEF_A_WIDTH / DEF_SLICE;
    localparam int unsigned NB          = DEF_B_WIDTH / DEF_SLICE;

    function automatic int unsigned shift_width(input int unsigned a_width,
                                                input int unsigned b_width);
        return $clog2(a_width + b_width);
    endfunction

    // A single-slice operand still gets a 1-bit index so ports never collapse to zero width.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_select.sv
// Combinational N-to-1 slice selector: returns data[index*SLICE +: SLICE].
module slice_select
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic [WIDTH-1:0]                        data,
    input  logic [index_width(WIDTH/SLICE)-1:0]     index,
    output logic [SLICE-1:0]                        slice
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned IW = index_width(N);

    always_comb begin
        slice = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (index == IW'(k)) slice = data[k*SLICE +: SLICE];
        end
    end

endmodule

// File: rtl/operand_slice_mux.sv
// Registered operand slice sequencer: walks every (A-slice, B-slice) pair under valid/ready.
// Optional macro SLICE_MUX_SKIP_ZERO_EN suppresses pairs containing a zero slice.
module operand_slice_mux
    import seq_mult_pkg::*;
#(
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH = DEF_B_WIDTH,
    parameter int unsigned SLICE   = DEF_SLICE
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start_i,
    input  logic [A_WIDTH-1:0]                    a_i,
    input  logic [B_WIDTH-1:0]                    b_i,
    output logic                                  busy_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [SLICE-1:0]                      a_slice_o,
    output logic [SLICE-1:0]                      b_slice_o,
    output logic [shift_width(A_WIDTH,B_WIDTH)-1:0] shift_o,
    output logic                                  last_o,
    output logic                                  done_o
);

    localparam int unsigned N_A = A_WIDTH / SLICE;
    localparam int unsigned N_B = B_WIDTH / SLICE;
    localparam int unsigned IA  = index_width(N_A);
    localparam int unsigned IB  = index_width(N_B);
    localparam int unsigned SW  = shift_width(A_WIDTH, B_WIDTH);

`ifdef SLICE_MUX_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    slice_mux_state_t     state, state_n;
    logic [IA-1:0]        i_q, i_n;
    logic [IB-1:0]        j_q, j_n;
    logic [A_WIDTH-1:0]   a_q, a_n;
    logic [B_WIDTH-1:0]   b_q, b_n;
    logic                 advance;
    logic                 valid_n;
    logic                 last_n;
    logic [SLICE-1:0]     sa_n, sb_n;
    logic [SW-1:0]        shift_n;

    // A non-presented (skipped) pair advances without waiting for the consumer.
    always_comb begin
        state_n = state;
        i_n     = i_q;
        j_n     = j_q;
        a_n     = a_q;
        b_n     = b_q;
        advance = (out_valid_o && out_ready_i) || (SKIP_ZERO && !out_valid_o);
        case (state)
            IDLE: begin
                if (start_i) begin
                    a_n     = a_i;
                    b_n     = b_i;
                    i_n     = '0;
                    j_n     = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    if (i_q == IA'(N_A - 1)) begin
                        i_n = '0;
                        if (j_q == IB'(N_B - 1)) begin
                            j_n     = '0;
                            state_n = DONE;
                        end else begin
                            j_n = j_q + 1'b1;
                        end
                    end else begin
                        i_n = i_q + 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    slice_select #(.WIDTH(A_WIDTH), .SLICE(SLICE)) u_sel_a (
        .data  (a_n),
        .index (i_n),
        .slice (sa_n)
    );

    slice_select #(.WIDTH(B_WIDTH), .SLICE(SLICE)) u_sel_b (
        .data  (b_n),
        .index (j_n),
        .slice (sb_n)
    );

    // Outputs are computed from next-state values so every output is a flop.
    always_comb begin
        valid_n = (state_n == RUN) && (!SKIP_ZERO || ((sa_n != '0) && (sb_n != '0)));
        last_n  = valid_n && (i_n == IA'(N_A - 1)) && (j_n == IB'(N_B - 1));
        shift_n = SW'((32'(i_n) + 32'(j_n)) * SLICE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b0;
            a_slice_o   <= '0;
            b_slice_o   <= '0;
            shift_o     <= '0;
            last_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_n;
            i_q         <= i_n;
            j_q         <= j_n;
            a_q         <= a_n;
            b_q         <= b_n;
            busy_o      <= (state_n != IDLE);
            out_valid_o <= valid_n;
            a_slice_o   <= valid_n ? sa_n : '0;
            b_slice_o   <= valid_n ? sb_n : '0;
            shift_o     <= valid_n ? shift_n : '0;
            last_o      <= last_n;
            done_o      <= (state_n == DONE);
        end
    end

endmodule
